// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB(/HALT) sequencing with latched decode fields.
// Latency: strobes are combinational from state (and mem_ack); decode fields register at the end of DECODE.
// Backpressure: FETCH/MEM hold mem_req until mem_ack or a wait-counter timeout; HALT holds until resume.
//
// Ports: clk, rst_n (async active-low); opcode/func (instruction fields, used in DECODE);
//        mem_ack, resume (inputs); ir_we/pc_we/mem_req/mem_we/reg_we (state strobes);
//        jmp..syscall, alu_op (latched decode fields); state (debug); illegal/timeout (pulses); halted.
// Optional feature: define SYSCALL_HALT_EN to make syscall park the FSM in HALT until resume.
module multicycle_control_unit #(
    parameter int ALUOP_W = 4,
    parameter int WAIT_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               mem_ack,
    input  logic               resume,
    output logic               ir_we,
    output logic               pc_we,
    output logic               mem_req,
    output logic               mem_we,
    output logic               reg_we,
    output logic               jmp,
    output logic               jr,
    output logic               jal,
    output logic               beq,
    output logic               bne,
    output logic               bltz,
    output logic               sh,
    output logic               signed_ext,
    output logic               alu_src_b,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               syscall,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state,
    output logic               illegal,
    output logic               timeout,
    output logic               halted
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Sequence class picked in DECODE; selects the path after EXEC.
    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_ALU  = 3'd1,  // EXEC -> WB
        C_LW   = 3'd2,  // EXEC -> MEM -> WB
        C_ST   = 3'd3,  // EXEC -> MEM
        C_JMP  = 3'd4,  // EXEC only, pc_we (j, jr, branches)
        C_JAL  = 3'd5,  // EXEC (pc_we) -> WB
        C_SYS  = 3'd6
    } cls_t;

    typedef struct packed {
        logic       jmp;
        logic       jr;
        logic       jal;
        logic       beq;
        logic       bne;
        logic       bltz;
        logic       sh;
        logic       signed_ext;
        logic       alu_src_b;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       syscall;
        logic [3:0] alu_op;
        cls_t       cls;
    } dec_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

    state_t             state_q, state_d;
    dec_t               dec_q, dec_d;
    logic               legal;
    logic [WAIT_W-1:0]  wait_q;
    logic               term;
    // Low until the first clock edge after reset release, so no strobe fires while held in reset.
    logic               run_q;

    // ---------------- instruction decode ----------------
    always_comb begin
        dec_d = '0;
        legal = 1'b1;
        case (opcode)
            6'h00: begin
                dec_d.reg_dst = 1'b1;
                dec_d.cls     = C_ALU;
                case (func)
                    6'h00: dec_d.alu_op = 4'd0;   // sll
                    6'h02: dec_d.alu_op = 4'd2;   // srl
                    6'h03: dec_d.alu_op = 4'd1;   // sra
                    6'h08: begin dec_d.jr = 1'b1;      dec_d.cls = C_JMP; end
                    6'h0C: begin dec_d.syscall = 1'b1; dec_d.cls = C_SYS; end
                    6'h20, 6'h21: dec_d.alu_op = 4'd5;
                    6'h22, 6'h23: dec_d.alu_op = 4'd6;
                    6'h24: dec_d.alu_op = 4'd7;
                    6'h25: dec_d.alu_op = 4'd8;
                    6'h26: dec_d.alu_op = 4'd9;
                    6'h27: dec_d.alu_op = 4'd10;
                    6'h2A: dec_d.alu_op = 4'd11;
                    6'h2B: dec_d.alu_op = 4'd12;
                    default: legal = 1'b0;
                endcase
            end
            6'h01: begin dec_d.bltz = 1'b1; dec_d.signed_ext = 1'b1; dec_d.alu_op = 4'd5; dec_d.cls = C_JMP; end
            6'h02: begin dec_d.jmp = 1'b1; dec_d.cls = C_JMP; end
            6'h03: begin dec_d.jal = 1'b1; dec_d.cls = C_JAL; end
            6'h04: begin dec_d.beq = 1'b1; dec_d.cls = C_JMP; end
            6'h05: begin dec_d.bne = 1'b1; dec_d.cls = C_JMP; end
            6'h08, 6'h09: begin
                dec_d.signed_ext = 1'b1; dec_d.alu_src_b = 1'b1; dec_d.alu_op = 4'd5; dec_d.cls = C_ALU;
            end
            6'h0A: begin dec_d.signed_ext = 1'b1; dec_d.alu_src_b = 1'b1; dec_d.alu_op = 4'd11; dec_d.cls = C_ALU; end
            6'h0C: begin dec_d.alu_src_b = 1'b1; dec_d.alu_op = 4'd7; dec_d.cls = C_ALU; end
            6'h0D: begin dec_d.alu_src_b = 1'b1; dec_d.alu_op = 4'd8; dec_d.cls = C_ALU; end
            6'h23: begin dec_d.alu_src_b = 1'b1; dec_d.mem_to_reg = 1'b1; dec_d.alu_op = 4'd5; dec_d.cls = C_LW; end
            6'h29: begin
                dec_d.sh = 1'b1; dec_d.signed_ext = 1'b1; dec_d.alu_src_b = 1'b1; dec_d.alu_op = 4'd5; dec_d.cls = C_ST;
            end
            6'h2B: begin dec_d.alu_src_b = 1'b1; dec_d.alu_op = 4'd5; dec_d.cls = C_ST; end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec_d = '0;
        end
    end

    // ---------------- next state and strobes ----------------
    always_comb begin
        state_d = state_q;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        reg_we  = 1'b0;
        illegal = 1'b0;
        timeout = 1'b0;
        halted  = 1'b0;
        term    = (wait_q == WAIT_MAX);
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                // An ack on the terminal-count cycle takes priority over the timeout.
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = DECODE;
                end else if (term) begin
                    timeout = 1'b1;
                    state_d = FETCH;
                end
            end
            DECODE: begin
                if (!legal) begin
                    illegal = 1'b1;
                    state_d = FETCH;
`ifdef SYSCALL_HALT_EN
                end else if (dec_d.cls == C_SYS) begin
                    state_d = HALT;
`endif
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                pc_we = (dec_q.cls == C_JMP) || (dec_q.cls == C_JAL);
                case (dec_q.cls)
                    C_ALU, C_JAL: state_d = WB;
                    C_LW,  C_ST:  state_d = MEM;
                    default:      state_d = FETCH;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = (dec_q.cls == C_ST);
                if (mem_ack) begin
                    state_d = (dec_q.cls == C_LW) ? WB : FETCH;
                end else if (term) begin
                    timeout = 1'b1;
                    state_d = FETCH;
                end
            end
            WB: begin
                reg_we  = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                halted = 1'b1;
`ifdef SYSCALL_HALT_EN
                if (resume) begin
                    state_d = FETCH;
                end
`else
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
        if (!run_q) begin
            state_d = FETCH;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
            reg_we  = 1'b0;
            illegal = 1'b0;
            timeout = 1'b0;
        end
    end

`ifndef SYSCALL_HALT_EN
    logic resume_unused;
    assign resume_unused = resume;
`endif

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            state_q <= FETCH;
            wait_q  <= '0;
            dec_q   <= '0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            // Counter only runs during an unacknowledged memory wait; any other cycle
            // (including ack or timeout) leaves it at zero for the next FETCH/MEM entry.
            if (mem_req && !mem_ack && !term) begin
                wait_q <= wait_q + 1'b1;
            end else begin
                wait_q <= '0;
            end
            if (run_q && state_q == DECODE) begin
                dec_q <= dec_d;
            end
        end
    end

    assign jmp        = dec_q.jmp;
    assign jr         = dec_q.jr;
    assign jal        = dec_q.jal;
    assign beq        = dec_q.beq;
    assign bne        = dec_q.bne;
    assign bltz       = dec_q.bltz;
    assign sh         = dec_q.sh;
    assign signed_ext = dec_q.signed_ext;
    assign alu_src_b  = dec_q.alu_src_b;
    assign reg_dst    = dec_q.reg_dst;
    assign mem_to_reg = dec_q.mem_to_reg;
    assign syscall    = dec_q.syscall;
    assign alu_op     = ALUOP_W'(dec_q.alu_op);
    assign state      = state_q;

endmodule
